// File: rtl/line_buffer_feeder.sv
// Raster-order feeder from feature-map RAM into the convolver's 3x3 line buffer.
// Read data passes straight through when the convolver accepts it; a one-entry skid holds it otherwise.
module line_buffer_feeder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  row_length,
    input  logic [DIM_W-1:0]  num_rows,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] lb_inp,
    output logic              lb_shifting,
    output logic              lb_reset,
    output logic [DIM_W-1:0]  lb_row_length,
    output logic              window_valid,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int IDX_W = 2 * DIM_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [DIM_W-1:0]    cols_q, rows_q;
    logic                bad_q;
    logic [IDX_W-1:0]    last_idx_q, rd_idx_q;
    logic                rd_pend_q;
    logic [DATA_W-1:0]   pix_q;
    logic                pix_v_q, pix_v_d;
    logic [DIM_W-1:0]    row_q, col_q;
    logic                win_q, win_d;

    logic rd_fire, shift, cfg_bad, last_pix, last_col;

    assign cfg_bad  = (row_length < DIM_W'(3)) || (num_rows < DIM_W'(3));
    assign rd_fire  = (state_q == S_STREAM) && !hold;
    // A pixel is available either from the read issued last cycle or from the skid entry.
    assign shift    = (rd_pend_q || pix_v_q) && !hold;
    assign last_col = (col_q == cols_q - DIM_W'(1));
    assign last_pix = shift && last_col && (row_q == rows_q - DIM_W'(1));
    assign pix_v_d  = (rd_pend_q || pix_v_q) && hold;
    assign win_d    = shift && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = cfg_bad ? S_DONE : S_CLEAR;
            S_CLEAR:  state_d = S_STREAM;
            S_STREAM: if (rd_fire && (rd_idx_q == last_idx_q)) state_d = S_DRAIN;
            S_DRAIN:  if (last_pix) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en     = rd_fire;
        mem_rd_addr   = base_q + ADDR_W'(rd_idx_q);
        lb_inp        = rd_pend_q ? mem_rd_data : pix_q;
        lb_shifting   = shift;
        lb_reset      = (state_q == S_CLEAR);
        lb_row_length = cols_q;
        window_valid  = win_q;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        cfg_err       = (state_q == S_DONE) && bad_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q     <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            bad_q      <= 1'b0;
            last_idx_q <= '0;
            rd_idx_q   <= '0;
            rd_pend_q  <= 1'b0;
            pix_q      <= '0;
            pix_v_q    <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            win_q      <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                base_q     <= base_addr;
                cols_q     <= row_length;
                rows_q     <= num_rows;
                bad_q      <= cfg_bad;
                last_idx_q <= IDX_W'(row_length) * IDX_W'(num_rows) - IDX_W'(1);
            end
            if (state_q == S_CLEAR) begin
                rd_idx_q <= '0;
            end else if (rd_fire) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
            rd_pend_q <= rd_fire;
            if (rd_pend_q) begin
                pix_q <= mem_rd_data;
            end
            pix_v_q <= pix_v_d;
            if (state_q == S_CLEAR) begin
                row_q <= '0;
                col_q <= '0;
            end else if (shift) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + DIM_W'(1);
                end else begin
                    col_q <= col_q + DIM_W'(1);
                end
            end
            win_q <= win_d;
        end
    end

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Directed bench for line_buffer_feeder: RAM model returns addr[7:0], events are logged per cycle and checked.
module tb_line_buffer_feeder;

    logic        clk = 1'b0;
    logic        rst, start, hold;
    logic [15:0] base_addr;
    logic [8:0]  row_length, num_rows;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data = '0;
    logic [15:0] lb_inp;
    logic        lb_shifting, lb_reset, window_valid, busy, done, cfg_err;
    logic [8:0]  lb_row_length;
    logic [47:0] outs;

    logic [15:0] rd_a[$], sh_v[$], win_v[$], exp_q[$];
    int          rd_c[$], sh_c[$], win_c[$], done_c[$], cfg_c[$], lbr_c[$];
    int          busy_n, cyc, n_chk, n_fail, t0, t1;
    logic [15:0] prev_sh;

    line_buffer_feeder dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_length(row_length), .num_rows(num_rows), .hold(hold),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .lb_inp(lb_inp), .lb_shifting(lb_shifting), .lb_reset(lb_reset),
        .lb_row_length(lb_row_length), .window_valid(window_valid),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= {8'h00, mem_rd_addr[7:0]};

    assign outs = {mem_rd_en, mem_rd_addr, lb_inp, lb_shifting, lb_reset, lb_row_length,
                   window_valid, busy, done, cfg_err};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_a.delete(); rd_c.delete(); sh_v.delete(); sh_c.delete();
        win_v.delete(); win_c.delete(); done_c.delete(); cfg_c.delete(); lbr_c.delete();
        busy_n = 0;
        prev_sh = '0;
    endtask

    // One clock cycle: drive inputs just after the rising edge, log outputs at the falling edge.
    task automatic step(input logic st, input logic hd);
        @(posedge clk);
        #1;
        start = st;
        hold  = hd;
        cyc++;
        @(negedge clk);
        if (mem_rd_en)    begin rd_a.push_back(mem_rd_addr); rd_c.push_back(cyc); end
        if (window_valid) begin win_v.push_back(prev_sh); win_c.push_back(cyc); end
        if (lb_shifting)  begin sh_v.push_back(lb_inp); sh_c.push_back(cyc); prev_sh = lb_inp; end
        if (done)     done_c.push_back(cyc);
        if (cfg_err)  cfg_c.push_back(cyc);
        if (lb_reset) lbr_c.push_back(cyc);
        if (busy)     busy_n++;
    endtask

    task automatic run_frame(input logic [15:0] b, input logic [8:0] c, input logic [8:0] r,
                             input int hold_at, input int hold_len, input int mid_start,
                             output int ts);
        int   hold_cnt;
        logic st, hd;
        base_addr  = b;
        row_length = c;
        num_rows   = r;
        clear_log();
        step(1'b1, 1'b0);
        ts = cyc;
        hold_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (done_c.size() != 0) break;
            st = (mid_start > 0) && (cyc + 1 == ts + mid_start);
            hd = (hold_cnt > 0);
            if (hold_cnt > 0) hold_cnt--;
            step(st, hd);
            if (hold_at >= 0 && rd_c.size() > 0 && rd_c[$] == cyc && rd_a[$] == hold_at[15:0])
                hold_cnt = hold_len;
        end
        chk("frame_done_count", done_c.size(), 1);
    endtask

    // Reads at t_rd+i; reads from index g on, and shifts from index g-1 on, are delayed by gap.
    task automatic check_stream(input string tag, input logic [15:0] b, input int n,
                                input int t_rd, input int g, input int gap);
        logic [15:0] a;
        int          d;
        chk({tag, "_nrd"}, rd_a.size(), n);
        chk({tag, "_nsh"}, sh_v.size(), n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            exp_q.push_back({8'h00, a[7:0]});
        end
        for (int i = 0; i < n && i < rd_a.size(); i++) begin
            a = b + 16'(i);
            d = (i >= g) ? gap : 0;
            chk({tag, "_rd_addr"}, rd_a[i], a);
            chk({tag, "_rd_cyc"}, rd_c[i], t_rd + i + d);
        end
        for (int i = 0; i < n && i < sh_v.size(); i++) begin
            d = (i >= g - 1) ? gap : 0;
            chk({tag, "_sh_val"}, sh_v[i], exp_q.pop_front());
            chk({tag, "_sh_cyc"}, sh_c[i], t_rd + 1 + i + d);
        end
    endtask

    task automatic check_wins4(input string tag);
        logic [15:0] wexp[4];
        wexp = '{16'h000A, 16'h000B, 16'h000E, 16'h000F};
        chk({tag, "_nwin"}, win_v.size(), 4);
        for (int i = 0; i < 4 && i < win_v.size(); i++) chk({tag, "_win_pix"}, win_v[i], wexp[i]);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        base_addr = '0; row_length = '0; num_rows = '0;
        clear_log();
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 48'h0);
        rst = 1'b1;

        // Basic 4x4 frame
        run_frame(16'h0100, 9'd4, 9'd4, -1, 0, -1, t0);
        chk("basic_nlbr", lbr_c.size(), 1);
        chk("basic_lbr_cyc", lbr_c[0], t0 + 1);
        check_stream("basic", 16'h0100, 16, t0 + 2, 16, 0);
        check_wins4("basic");
        chk("basic_done_cyc", done_c[0], t0 + 19);
        chk("basic_done_with_last_win", win_c[3], t0 + 19);
        chk("basic_ncfg", cfg_c.size(), 0);
        chk("basic_busy_cycles", busy_n, 19);
        chk("basic_row_len", lb_row_length, 9'd4);
        step(1'b0, 1'b0);
        chk("basic_busy_after", busy, 1'b0);

        // Backpressure: hold for 3 cycles after the read of 0x0105
        run_frame(16'h0100, 9'd4, 9'd4, 16'h0105, 3, -1, t0);
        check_stream("bp", 16'h0100, 16, t0 + 2, 6, 3);
        check_wins4("bp");
        chk("bp_done_cyc", done_c[0], t0 + 22);
        chk("bp_done_with_last_win", win_c[3], t0 + 22);

        // Config rejects
        run_frame(16'h0100, 9'd2, 9'd5, -1, 0, -1, t0);
        chk("rej1_done_cyc", done_c[0], t0 + 1);
        chk("rej1_ncfg", cfg_c.size(), 1);
        chk("rej1_cfg_cyc", cfg_c[0], t0 + 1);
        chk("rej1_nrd", rd_a.size(), 0);
        chk("rej1_nlbr", lbr_c.size(), 0);
        chk("rej1_busy_cycles", busy_n, 1);
        chk("rej1_row_len", lb_row_length, 9'd2);
        run_frame(16'h0100, 9'd5, 9'd2, -1, 0, -1, t0);
        chk("rej2_done_cyc", done_c[0], t0 + 1);
        chk("rej2_ncfg", cfg_c.size(), 1);
        chk("rej2_cfg_cyc", cfg_c[0], t0 + 1);
        chk("rej2_nrd", rd_a.size(), 0);
        chk("rej2_nlbr", lbr_c.size(), 0);
        chk("rej2_busy_cycles", busy_n, 1);

        // Asynchronous reset after 7 reads, then a fresh 3x3 frame
        base_addr = 16'h0100; row_length = 9'd4; num_rows = 9'd4;
        step(1'b0, 1'b0);
        clear_log();
        step(1'b1, 1'b0);
        for (int k = 0; k < 50 && rd_a.size() < 7; k++) step(1'b0, 1'b0);
        chk("abort_nrd", rd_a.size(), 7);
        #2 rst = 1'b0;
        #1 chk("abort_outputs_zero", outs, 48'h0);
        chk("abort_ndone", done_c.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_frame(16'h0200, 9'd3, 9'd3, -1, 0, -1, t0);
        check_stream("post_rst", 16'h0200, 9, t0 + 2, 9, 0);
        chk("post_rst_nwin", win_v.size(), 1);
        chk("post_rst_win_pix", win_v[0], 16'h0008);
        chk("post_rst_done_cyc", done_c[0], t0 + 12);

        // Ignored mid-frame start, then back-to-back frame with address wrap
        run_frame(16'h0300, 9'd4, 9'd4, -1, 0, 8, t0);
        check_stream("ign", 16'h0300, 16, t0 + 2, 16, 0);
        chk("ign_nlbr", lbr_c.size(), 1);
        chk("ign_done_cyc", done_c[0], t0 + 19);
        run_frame(16'hFFFE, 9'd3, 9'd3, -1, 0, -1, t1);
        chk("wrap_lbr_cyc", lbr_c[0], t1 + 1);
        check_stream("wrap", 16'hFFFE, 9, t1 + 2, 9, 0);
        chk("wrap_nwin", win_v.size(), 1);
        chk("wrap_win_pix", win_v[0], 16'h0006);
        chk("wrap_done_cyc", done_c[0], t1 + 12);
        chk("wrap_row_len", lb_row_length, 9'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
